// File: rtl/pc_next_unit.sv
// Fetch PC stage: resolves branches/jumps from decode, holds PC across stalls.
// Optional architectural delay slot via `PC_DELAY_SLOT_EN.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] ins,
  input  logic        ins_valid,
  input  logic        compare,
  input  logic        branch,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_d,
  output logic [31:0] link_addr,
  output logic        redirect,
  output logic        flush,
  output logic [0:0]  state
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [5:0]  op;
  logic [4:0]  rt;
  logic [5:0]  funct;
  logic        is_cond;
  logic        is_jump;
  logic        is_jr;
  logic        taken;
  logic [31:0] seq_d;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] target;
  logic [31:0] pend_target;

  assign op    = ins[31:26];
  assign rt    = ins[20:16];
  assign funct = ins[5:0];

  // REGIMM with rt outside {0,1} leaves the comparator stale, so it never counts as taken.
  assign is_cond = ins_valid &&
                   ((op == 6'b000100) || (op == 6'b000101) ||
                    (op == 6'b000110) || (op == 6'b000111) ||
                    ((op == 6'b000001) && (rt[4:1] == 4'b0000)));
  assign is_jump = ins_valid && ((op == 6'b000010) || (op == 6'b000011));
  assign is_jr   = ins_valid && (op == 6'b000000) &&
                   ((funct == 6'b001000) || (funct == 6'b001001));
  assign taken   = (is_cond && compare && branch) || is_jump || is_jr;

  assign seq_d     = pc_d + 32'd4;
  assign br_target = seq_d + {{14{ins[15]}}, ins[15:0], 2'b00};
  assign j_target  = {seq_d[31:28], ins[25:0], 2'b00};

  always_comb begin
    target = br_target;
    if (is_jr)        target = rs_data;
    else if (is_jump) target = j_target;
  end

  // In PEND the decision is already made; decode inputs are ignored.
  assign redirect = !rst && !stall && ((state == PEND) || taken);

`ifdef PC_DELAY_SLOT_EN
  assign flush     = 1'b0;
  assign link_addr = pc_d + 32'd8;
`else
  assign flush     = redirect;
  assign link_addr = pc_d + 32'd4;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      pc_d        <= 32'd0;
      pend_target <= 32'd0;
      state       <= RUN;
    end else if (stall) begin
      if ((state == RUN) && taken) begin
        pend_target <= target;
        state       <= PEND;
      end
    end else begin
      pc_d <= pc;
      if (state == PEND) begin
        pc    <= pend_target;
        state <= RUN;
      end else if (taken) begin
        pc <= target;
      end else begin
        pc <= pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed self-checking bench for pc_next_unit; expectations follow the
// PC_DELAY_SLOT_EN setting used for the build.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] ins;
  logic        ins_valid;
  logic        compare;
  logic        branch;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_d;
  logic [31:0] link_addr;
  logic        redirect;
  logic        flush;
  logic [0:0]  state;

  int tests = 0;
  int fails = 0;

`ifdef PC_DELAY_SLOT_EN
  localparam logic        FL_T  = 1'b0;
  localparam logic [31:0] LINK  = 32'd8;
`else
  localparam logic        FL_T  = 1'b1;
  localparam logic [31:0] LINK  = 32'd4;
`endif

  pc_next_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .ins(ins), .ins_valid(ins_valid),
    .compare(compare), .branch(branch), .rs_data(rs_data), .pc(pc),
    .pc_d(pc_d), .link_addr(link_addr), .redirect(redirect), .flush(flush),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply decode inputs and let combinational outputs settle.
  task automatic drive(input logic [31:0] i, input logic v, input logic c,
                       input logic b, input logic [31:0] rs);
    ins = i; ins_valid = v; compare = c; branch = b; rs_data = rs;
    #1;
  endtask

  task automatic idle();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    idle();
    step(); step();
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_pc_d", pc_d, 32'h0);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_state", {31'd0, state}, 32'd0);

    rst = 1'b0;
    step(); chk("seq1_pc", pc, 32'h3004);
    step(); chk("seq2_pc", pc, 32'h3008);
    chk("seq2_pc_d", pc_d, 32'h3004);

    // BEQ taken, offset +3 words
    drive(32'h1085_0003, 1'b1, 1'b1, 1'b1, 32'h0);
    chk("beq_redirect", {31'd0, redirect}, 32'd1);
    chk("beq_flush", {31'd0, flush}, {31'd0, FL_T});
    step(); chk("beq_pc", pc, 32'h3014);
    chk("beq_pc_d", pc_d, 32'h3008);

    // BNE not taken
    drive(32'h1485_0003, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("bne_nt_redirect", {31'd0, redirect}, 32'd0);
    step(); chk("bne_nt_pc", pc, 32'h3018);

    // REGIMM rt=00010 with stale branch=1: not taken
    drive(32'h0482_0003, 1'b1, 1'b1, 1'b1, 32'h0);
    chk("regimm_stale_redirect", {31'd0, redirect}, 32'd0);
    chk("regimm_stale_flush", {31'd0, flush}, 32'd0);
    step(); chk("regimm_stale_pc", pc, 32'h301C);

    // REGIMM rt=00001 (BGEZ) taken: pc_d=0x3018 -> 0x301C+12
    drive(32'h0481_0003, 1'b1, 1'b1, 1'b1, 32'h0);
    chk("bgez_redirect", {31'd0, redirect}, 32'd1);
    step(); chk("bgez_pc", pc, 32'h3028);

    // BNE taken with negative offset: pc_d=0x301C -> 0x3020-8
    drive(32'h1485_FFFE, 1'b1, 1'b1, 1'b1, 32'h0);
    step(); chk("bne_neg_pc", pc, 32'h3018);
    chk("bne_neg_pc_d", pc_d, 32'h3028);

    // BEQ with compare=0: branch ignored
    drive(32'h1085_0003, 1'b1, 1'b0, 1'b1, 32'h0);
    chk("beq_nocmp_redirect", {31'd0, redirect}, 32'd0);
    step(); chk("beq_nocmp_pc", pc, 32'h301C);

    // J to 0x3040 (pc_d=0x3018)
    drive(32'h0800_0C10, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("j_redirect", {31'd0, redirect}, 32'd1);
    step(); chk("j_pc", pc, 32'h3040);

    // JAL to 0x3080; link from pc_d=0x301C
    drive(32'h0C00_0C20, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("jal_link", link_addr, 32'h301C + LINK);
    step(); chk("jal_pc", pc, 32'h3080);

    // JR to 0x3100
    drive(32'h0080_0008, 1'b1, 1'b0, 1'b0, 32'h0000_3100);
    chk("jr_redirect", {31'd0, redirect}, 32'd1);
    step(); chk("jr_pc", pc, 32'h3100);
    chk("jr_pc_d", pc_d, 32'h3080);

    // JALR to an unaligned high address, no alignment applied
    drive(32'h0080_0009, 1'b1, 1'b0, 1'b0, 32'hF000_0001);
    chk("jalr_link", link_addr, 32'h3080 + LINK);
    step(); chk("jalr_pc", pc, 32'hF000_0001);
    idle();
    step(); chk("hi_seq_pc", pc, 32'hF000_0005);

    // J keeps upper nibble of pc_d+4 (pc_d=0xF0000001)
    drive(32'h0800_0C10, 1'b1, 1'b0, 1'b0, 32'h0);
    step(); chk("j_hi_pc", pc, 32'hF000_3040);

    // J word marked as bubble: sequential
    drive(32'h0800_0C10, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("bubble_redirect", {31'd0, redirect}, 32'd0);
    step(); chk("bubble_pc", pc, 32'hF000_3044);

    // Back to 0x3000, then walk to pc_d=0x3004
    drive(32'h0080_0008, 1'b1, 1'b0, 1'b0, 32'h0000_3000);
    step(); idle(); step(); step();
    chk("rewind_pc", pc, 32'h3008);
    chk("rewind_pc_d", pc_d, 32'h3004);

    // Stalled taken BEQ -> PEND
    stall = 1'b1;
    drive(32'h1085_0003, 1'b1, 1'b1, 1'b1, 32'h0);
    chk("stall_redirect", {31'd0, redirect}, 32'd0);
    step(); chk("stall1_pc", pc, 32'h3008);
    chk("stall1_state", {31'd0, state}, 32'd1);
    drive(32'h1085_0003, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("pend_stall_redirect", {31'd0, redirect}, 32'd0);
    step(); step();
    chk("stall3_pc", pc, 32'h3008);
    chk("stall3_pc_d", pc_d, 32'h3004);
    chk("stall3_state", {31'd0, state}, 32'd1);

    // Release with a J in decode: the pending target wins
    stall = 1'b0;
    drive(32'h0800_0C10, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("pend_rel_redirect", {31'd0, redirect}, 32'd1);
    chk("pend_rel_flush", {31'd0, flush}, {31'd0, FL_T});
    step(); chk("pend_rel_pc", pc, 32'h3014);
    chk("pend_rel_pc_d", pc_d, 32'h3008);
    chk("pend_rel_state", {31'd0, state}, 32'd0);

    // Reset mid-PEND discards the pending target (0x3018)
    stall = 1'b1;
    drive(32'h1085_0003, 1'b1, 1'b1, 1'b1, 32'h0);
    step(); chk("pend2_state", {31'd0, state}, 32'd1);
    rst = 1'b1; #1;
    chk("rst_pend_redirect", {31'd0, redirect}, 32'd0);
    step();
    chk("rst_pend_pc", pc, 32'h3000);
    chk("rst_pend_pc_d", pc_d, 32'h0);
    chk("rst_pend_state", {31'd0, state}, 32'd0);
    rst = 1'b0; stall = 1'b0;
    idle();
    chk("post_rst_redirect", {31'd0, redirect}, 32'd0);
    step(); chk("post_rst_pc", pc, 32'h3004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Fetch-side program-counter stage of the MIPS datapath, directly downstream of the decode-stage branch comparator. It consumes the comparator's `branch` result with the decode-stage instruction and register data. It resolves conditional branches, J/JAL and JR/JALR into a next fetch address. It holds the PC under pipeline stalls, keeping any taken target pending across them, and optionally implements the architectural branch delay slot.

## Interface
- `RESET_PC`, 32'h0000_3000: fetch address loaded on reset.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hazard hold; fetch PC and decode PC do not advance.
- `ins`  in  32: instruction in decode, the same word driven to the comparator.
- `ins_valid`  in  1: `ins` is a real instruction (0 = bubble).
- `compare`  in  1: decode instruction is a conditional branch; the same strobe is driven to the comparator.
- `branch`  in  1: comparator result; sampled only when `compare`=1.
- `rs_data`  in  32: rs register value, the JR/JALR target.
- `pc`  out  32: current fetch address.
- `pc_d`  out  32: address of the instruction in decode.
- `link_addr`  out  32: JAL/JALR return address.
- `redirect`  out  1: the next edge loads a non-sequential PC.
- `flush`  out  1: squash the instruction fetched this cycle. Only used when delay slots are disabled.

## Operation
- Decoded classes (`ins_valid`=1):
  - Conditional: op BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111, or REGIMM 000001 with rt ∈ {00000, 00001}. Taken iff `compare`=1 and `branch`=1.
  - REGIMM with any other rt: treated as not taken, whatever `branch` holds (the comparator leaves it stale).
  - J 000010 and JAL 000011: always taken.
  - SPECIAL 000000 with funct JR 001000 or JALR 001001: always taken.
- Targets (32-bit, wrap modulo 2^32):
  - Branch: `pc_d`+4+(sign_ext(ins[15:0])<<2).
  - Jump: {(`pc_d`+4)[31:28], ins[25:0], 2'b00}.
  - Register jump: `rs_data` unmodified; no alignment check.
- Sequential next address: `pc`+4.
- Update priority: `rst` > `stall` > taken transfer > sequential.
- States:
  - RUN: normal operation.
  - PEND: taken target latched, waiting for the stall to clear.
- Transitions:
  - RUN, taken, `stall`=0: `pc` ← target; `redirect`=1; stay in RUN.
  - RUN, taken, `stall`=1: `pend_target` ← target; go to PEND; `pc` held.
  - PEND, `stall`=1: hold. `ins`, `compare` and `branch` are ignored because the decision is already made.
  - PEND, `stall`=0: `pc` ← `pend_target`; `redirect`=1; go to RUN.
- `pc_d` ← `pc` on every non-stalled edge, including redirect edges.
- `redirect` and `flush` are combinational from state and inputs, and forced to 0 while `rst`=1.
- Reset values: `pc`=`RESET_PC`, `pc_d`=0, `pend_target`=0, state RUN, `redirect`=0, `flush`=0.
- Reset mid-PEND discards the pending target.

## Timing
- Decision latency is zero cycles: the taken target is visible on `pc` the edge after decode, provided `stall`=0.
- A stalled taken transfer takes effect on the first edge with `stall`=0.
- `link_addr` is combinational from `pc_d`: `pc_d`+8 with delay slots, `pc_d`+4 without.
- `branch` is sampled in the same cycle as `compare`. The comparator output must be settled before the edge (single-cycle path).

## Configuration
- `PC_DELAY_SLOT_EN` defined:
  - The instruction fetched during a taken transfer is the delay slot and executes.
  - `flush` is tied to 0.
  - `link_addr`=`pc_d`+8.
- `PC_DELAY_SLOT_EN` undefined:
  - `flush`=`redirect`, so the fall-through fetch is squashed.
  - `link_addr`=`pc_d`+4.
  - Taken-transfer penalty is one bubble.

## Test plan
- Reset: hold `rst`=1 for 2 edges → `pc`=0x0000_3000, `pc_d`=0, `redirect`=0. Release with 3 non-stalled edges → `pc` steps through 0x3004, 0x3008, 0x300C.
- BEQ taken: `pc_d`=0x3004, `ins`=0x1085_0003, `compare`=1, `branch`=1 → `redirect`=1; next `pc`=0x0000_3014. With the macro, `flush`=0; without it, `flush`=1.
- BNE not taken, then stale REGIMM:
  - BNE with `branch`=0 → `pc`=`pc`+4, `redirect`=0.
  - REGIMM rt=00010 with `branch`=1 → not taken.
- J: `pc_d`=0x3008, `ins`=0x0800_0C10 → next `pc`=0x0000_3040.
  - JAL: `link_addr`=0x3010 with the macro, 0x300C without.
  - JR: `rs_data`=0x0000_3100 → next `pc`=0x3100.
- Stalled branch:
  - Taken BEQ (target 0x3014) with `stall`=1 for 3 cycles → `pc` held, state PEND.
  - During PEND, drive `compare`=0, `branch`=0 → ignored.
  - Drop `stall` → `redirect`=1; `pc`=0x3014 on that edge.
- Reset mid-PEND: assert `rst` one edge while in PEND → `pc`=0x3000, state RUN, and the pending target is never loaded.
